// File: rtl/pipe_stage_buf_pkg.sv
// rtl/pipe_stage_buf_pkg.sv - shared command codes and constants for the pipeline stage buffer
package pipe_stage_buf_pkg;

    typedef enum logic [1:0] {
        STL_GO     = 2'b00,
        STL_STALL  = 2'b01,
        STL_BUBBLE = 2'b10,
        STL_RSVD   = 2'b11
    } stl_cmd_e;

    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/sync_fifo_ptr.sv
// rtl/sync_fifo_ptr.sv - skid FIFO storage with pointer/count bookkeeping and flush
module sync_fifo_ptr #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             dclk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign rdata   = mem[rptr];

    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (clear) begin
            // Flush by collapsing the read side onto the write side.
            rptr  <= wptr;
            count <= '0;
        end else begin
            if (do_push) wptr <= ptr_inc(wptr);
            if (do_pop)  rptr <= ptr_inc(rptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset; only pointers and count define what is live.
    always_ff @(posedge dclk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    a_count_bound: assert property (@(posedge dclk) disable iff (!rst) count <= CNT_W'(DEPTH));
    a_no_underflow: assert property (@(posedge dclk) disable iff (!rst) !(pop && empty && !clear));
    a_no_overflow: assert property (@(posedge dclk) disable iff (!rst) !(push && full && !clear));

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - inter-stage pipeline register with skid FIFO, bypass and go/stall/bubble control
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              dclk,
    input  logic              rst,
    input  logic [1:0]        stl_i,
    input  logic              in_valid_i,
    input  logic [INST_W-1:0] in_inst_i,
    input  logic [PC_W-1:0]   in_pc_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [INST_W-1:0] out_inst_o,
    output logic [PC_W-1:0]   out_pc_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int W = INST_W + PC_W;

    stl_cmd_e   cmd;
    logic       accept;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_clear;
    logic       fifo_full;
    logic       fifo_empty;
    logic [W-1:0] fifo_rdata;
    logic       load_en;
    logic       zero_en;
    logic [W-1:0] load_data;

    assign cmd        = stl_cmd_e'(stl_i);
    assign in_ready_o = ~fifo_full;
    assign accept     = in_valid_i & in_ready_o & (cmd != STL_BUBBLE);

    always_comb begin
        fifo_push  = DISABLE;
        fifo_pop   = DISABLE;
        fifo_clear = DISABLE;
        load_en    = DISABLE;
        zero_en    = DISABLE;
        load_data  = {in_inst_i, in_pc_i};
        case (cmd)
            STL_GO: begin
                if (!fifo_empty) begin
                    // Older items drain first; a new arrival queues behind them.
                    fifo_pop  = ENABLE;
                    fifo_push = accept;
                    load_en   = ENABLE;
                    load_data = fifo_rdata;
                end else if (accept) begin
                    load_en = ENABLE;
                end else begin
                    zero_en = ENABLE;
                end
            end
            STL_BUBBLE: begin
                fifo_clear = ENABLE;
                zero_en    = ENABLE;
            end
            default: begin
                fifo_push = accept;
            end
        endcase
    end

    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            out_valid_o <= DISABLE;
            out_inst_o  <= '0;
            out_pc_o    <= '0;
        end else if (load_en) begin
            out_valid_o <= ENABLE;
            out_inst_o  <= load_data[W-1:PC_W];
            out_pc_o    <= load_data[PC_W-1:0];
        end else if (zero_en) begin
            out_valid_o <= DISABLE;
            out_inst_o  <= '0;
            out_pc_o    <= '0;
        end
    end

    sync_fifo_ptr #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .dclk  (dclk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (fifo_clear),
        .wdata ({in_inst_i, in_pc_i}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count_o)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - scoreboard bench for pipe_stage_buf with directed vectors
module tb_pipe_stage_buf;

    logic        dclk = 1'b0;
    logic        rst  = 1'b0;
    logic [1:0]  stl_i = 2'b00;
    logic        in_valid_i = 1'b0;
    logic [31:0] in_inst_i = '0;
    logic [31:0] in_pc_i = '0;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] out_inst_o;
    logic [31:0] out_pc_o;
    logic [1:0]  count_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic        last_go = 1'b0;

    localparam logic [1:0] GO = 2'b00, ST = 2'b01, BU = 2'b10, RS = 2'b11;

    pipe_stage_buf dut (
        .dclk        (dclk),
        .rst         (rst),
        .stl_i       (stl_i),
        .in_valid_i  (in_valid_i),
        .in_inst_i   (in_inst_i),
        .in_pc_i     (in_pc_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_inst_o  (out_inst_o),
        .out_pc_o    (out_pc_o),
        .count_o     (count_o)
    );

    always #5 dclk = ~dclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step(input logic [1:0] c, input logic v, input logic [31:0] i, input logic [31:0] p);
        stl_i = c; in_valid_i = v; in_inst_i = i; in_pc_i = p;
        @(posedge dclk);
        @(negedge dclk);
        #1;
    endtask

    // A new item is presented on the cycle after a Go command with the slot valid.
    always @(posedge dclk or negedge rst) begin
        if (!rst) last_go = 1'b0;
        else      last_go = (stl_i == GO);
    end

    always @(negedge dclk) begin
        if (rst && last_go && out_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pc", {32'h0, out_pc_o}, 64'hFFFF_FFFF);
            end else begin
                chk("sb_item", {out_inst_o, out_pc_o}, exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(negedge dclk);
        #1;
        chk("rst_valid", {63'h0, out_valid_o}, 64'h0);
        chk("rst_inst",  {32'h0, out_inst_o}, 64'h0);
        chk("rst_pc",    {32'h0, out_pc_o}, 64'h0);
        chk("rst_count", {62'h0, count_o}, 64'h0);
        rst = 1'b1;
        #1;
        chk("rst_ready", {63'h0, in_ready_o}, 64'h1);

        // Bypass into an empty stage
        exp_q.push_back({32'h00A00093, 32'h4});
        step(GO, 1'b1, 32'h00A00093, 32'h4);
        chk("a_valid", {63'h0, out_valid_o}, 64'h1);
        chk("a_inst",  {32'h0, out_inst_o}, 64'h00A00093);
        chk("a_pc",    {32'h0, out_pc_o}, 64'h4);
        chk("a_count", {62'h0, count_o}, 64'h0);

        // Stall fills the skid FIFO; third item refused
        exp_q.push_back({32'h00B00113, 32'h8});
        step(ST, 1'b1, 32'h00B00113, 32'h8);
        chk("stall1_count", {62'h0, count_o}, 64'h1);
        chk("stall1_pc",    {32'h0, out_pc_o}, 64'h4);
        exp_q.push_back({32'h00C00193, 32'hC});
        step(ST, 1'b1, 32'h00C00193, 32'hC);
        chk("stall2_count", {62'h0, count_o}, 64'h2);
        chk("full_ready",   {63'h0, in_ready_o}, 64'h0);
        step(ST, 1'b1, 32'h00D00213, 32'h10);
        chk("stall3_count", {62'h0, count_o}, 64'h2);
        chk("stall3_pc",    {32'h0, out_pc_o}, 64'h4);

        // Drain with D re-presented until accepted
        exp_q.push_back({32'h00D00213, 32'h10});
        step(GO, 1'b1, 32'h00D00213, 32'h10);
        chk("go1_count", {62'h0, count_o}, 64'h1);
        chk("go1_pc",    {32'h0, out_pc_o}, 64'h8);
        step(GO, 1'b1, 32'h00D00213, 32'h10);
        chk("go2_count", {62'h0, count_o}, 64'h1);
        chk("go2_pc",    {32'h0, out_pc_o}, 64'hC);
        step(GO, 1'b0, 32'h0, 32'h0);
        chk("go3_count", {62'h0, count_o}, 64'h0);
        chk("go3_pc",    {32'h0, out_pc_o}, 64'h10);
        step(GO, 1'b0, 32'h0, 32'h0);
        chk("idle_valid", {63'h0, out_valid_o}, 64'h0);
        chk("idle_pc",    {32'h0, out_pc_o}, 64'h0);

        // Bubble flushes slot and a full FIFO, dropping the same-cycle item
        exp_q.push_back({32'h00E00293, 32'h14});
        step(GO, 1'b1, 32'h00E00293, 32'h14);
        step(ST, 1'b1, 32'h00F00313, 32'h18);
        step(ST, 1'b1, 32'h01000393, 32'h1C);
        chk("pre_bub_count", {62'h0, count_o}, 64'h2);
        exp_q.delete();
        step(BU, 1'b1, 32'h0BAD0013, 32'h20);
        chk("bub_valid", {63'h0, out_valid_o}, 64'h0);
        chk("bub_inst",  {32'h0, out_inst_o}, 64'h0);
        chk("bub_pc",    {32'h0, out_pc_o}, 64'h0);
        chk("bub_count", {62'h0, count_o}, 64'h0);
        chk("bub_ready", {63'h0, in_ready_o}, 64'h1);
        step(GO, 1'b0, 32'h0, 32'h0);
        chk("post_bub_valid", {63'h0, out_valid_o}, 64'h0);

        // Reserved code 2'b11 acts as Stall
        exp_q.push_back({32'h01100313, 32'h24});
        step(GO, 1'b1, 32'h01100313, 32'h24);
        exp_q.push_back({32'h01200393, 32'h28});
        step(RS, 1'b1, 32'h01200393, 32'h28);
        chk("rsvd_pc",    {32'h0, out_pc_o}, 64'h24);
        chk("rsvd_valid", {63'h0, out_valid_o}, 64'h1);
        chk("rsvd_count", {62'h0, count_o}, 64'h1);

        // Asynchronous reset between edges
        #1;
        rst = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_valid", {63'h0, out_valid_o}, 64'h0);
        chk("arst_inst",  {32'h0, out_inst_o}, 64'h0);
        chk("arst_pc",    {32'h0, out_pc_o}, 64'h0);
        chk("arst_count", {62'h0, count_o}, 64'h0);
        stl_i = GO; in_valid_i = 1'b0;
        @(negedge dclk);
        #1;
        rst = 1'b1;
        #1;
        chk("rel_count", {62'h0, count_o}, 64'h0);
        chk("rel_ready", {63'h0, in_ready_o}, 64'h1);

        exp_q.push_back({32'h01300413, 32'h2C});
        step(GO, 1'b1, 32'h01300413, 32'h2C);
        chk("j_pc",    {32'h0, out_pc_o}, 64'h2C);
        chk("j_count", {62'h0, count_o}, 64'h0);
        step(GO, 1'b0, 32'h0, 32'h0);
        chk("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor of the single-entry inter-stage pipeline latch; it sits between any two pipeline stages (IF/ID, ID/EX, ...).
- Holds a registered output slot plus a DEPTH-entry skid FIFO. Upstream can keep issuing while the downstream stage is stalled, until the FIFO is full.
- Keeps the 2-bit staller command semantics: go, stall, bubble. Bubble flushes the whole stage, including the FIFO.

Parameters:
- INST_W, 32, width of the instruction/payload field
- PC_W, 32, width of the PC field
- DEPTH, 2, skid FIFO entries; legal range 1..16, and values need not be powers of two
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden)

Ports:
- dclk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- stl_i  in  2  staller command: 2'b00 Go, 2'b01 Stall, 2'b10 Bubble, 2'b11 treated as Stall
- in_valid_i  in  1  upstream presents an item
- in_inst_i  in  INST_W  upstream instruction
- in_pc_i  in  PC_W  upstream PC
- in_ready_o  out  1  stage can accept an item this cycle
- out_valid_o  out  1  output slot holds a live item
- out_inst_o  out  INST_W  output instruction, registered
- out_pc_o  out  PC_W  output PC, registered
- count_o  out  CNT_W  FIFO occupancy, excluding the output slot

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid_o=0, out_inst_o=0, out_pc_o=0.
  - count_o=0; read and write pointers=0.
  - in_ready_o=1 once rst deasserts.
  - Reset mid-traffic drops all held items.
- in_ready_o = (count_o != DEPTH). It is combinational from the registered count only and does not depend on stl_i.
- push = in_valid_i & in_ready_o. It is ignored under Bubble.
- Go, FIFO non-empty:
  - The output slot loads the FIFO head; out_valid_o=1.
  - The read pointer advances.
  - A simultaneous push is written at the tail, so net count is unchanged.
- Go, FIFO empty, push:
  - Bypass: the output slot loads in_inst_i/in_pc_i directly; out_valid_o=1.
  - Count stays 0. Latency is 1 cycle, the same as a plain latch.
- Go, FIFO empty, no push: output slot is zeroed and out_valid_o=0 (bubble inserted).
- Stall (or 2'b11):
  - Output slot holds its value.
  - A push goes to the FIFO tail and count increments.
  - With the FIFO full, in_ready_o=0 and nothing is written.
- Bubble:
  - Output slot is zeroed; out_valid_o=0.
  - FIFO is emptied: count=0, rptr=wptr.
  - Any same-cycle in_valid_i item is dropped, because flushing kills younger instructions.
  - in_ready_o still reflects the pre-flush count for that cycle.
- Pointers wrap from DEPTH-1 to 0.
- Count never exceeds DEPTH and never underflows. Simulation assertions check both.
- Ordering: items leave in exactly push order, including across bypass and FIFO paths.
- FIFO storage is not reset. Only the pointers and count reset.

Decomposition:
- Shared package (macro header) holds:
  - the staller command codes Go/Stall/Bubble (2'b00/2'b01/2'b10)
  - Enable/Disable constants
  - ZeroWord
- One natural sub-module, sync_fifo_ptr: pointer/count bookkeeping plus the storage array. It is parametrised by width = INST_W+PC_W and DEPTH, and has push, pop, clear, full and empty.
- pipe_stage_buf adds the output slot, the bypass path and the command decode.

Test Plan:
- Reset, then Go with in_valid_i=1, inst=0x00A00093, pc=0x4:
  - next edge: out_valid_o=1, out_inst_o=0x00A00093, out_pc_o=0x4, count_o=0.
- Output holds A; Stall for 3 cycles while pushing B (pc 0x8), C (0xC), D (0x10) with DEPTH=2:
  - count_o goes 1, then 2.
  - in_ready_o=0 in the third cycle, so D is not accepted.
  - output stays A throughout.
- Continue from the previous state: Go 3 cycles, with D re-presented from cycle 1:
  - outputs B, C, D in order.
  - count_o goes 2, 1 (D written), 0.
- FIFO holding 2 items; Bubble with in_valid_i=1, pc=0x20:
  - next edge: out_valid_o=0, out_inst_o=0, out_pc_o=0, count_o=0.
  - the pc 0x20 item never appears.
- stl_i=2'b11 with output valid: behaves as Stall, so output holds and push goes to the FIFO.
- Assert rst=0 between clock edges while the FIFO holds 1 item:
  - outputs go to 0 immediately, without waiting for a clock edge.
  - after release: count_o=0, in_ready_o=1.
